fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Program-counter and fetch sequencer directly upstream of the 64-byte instruction memory. It drives the memory's byte address and active-low read enable, and captures the returned big-endian 32-bit word into an IF/ID output register with a valid/ready handshake toward decode. It also handles stalls, branch redirects, flushes, end-of-program halt and misaligned-target errors.

Parameters:
ADDR_W, 6, byte-address width; memory depth is 2**ADDR_W bytes.
INSTR_W, 32, instruction width.
RESET_PC, 6'd0, PC value loaded on reset; must be word-aligned.
HALT_WORD, 32'hFFFF_FFFF, sentinel word that stops fetching.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
stall  input  1  freeze fetch; PC held, no read issued.
branch_taken  input  1  single-cycle redirect request.
branch_target  input  ADDR_W  redirect byte address.
flush  input  1  invalidate the IF/ID register.
memread  output  1  memory read enable, active-low (0 = read).
read_address  output  ADDR_W  byte address to the memory; equals the PC.
instruction_re  input  INSTR_W  combinational memory data; valid in the same cycle memread=0.
if_instr  output  INSTR_W  registered instruction to decode.
if_pc  output  ADDR_W  address of if_instr.
if_valid  output  1  if_instr/if_pc hold a live instruction.
id_ready  input  1  decode accepts when if_valid && id_ready.
fetch_err  output  1  sticky misaligned-target error.
halted  output  1  high while in HALT.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=IDLE, memread=1, if_valid=0, if_instr=0, if_pc=0, fetch_err=0, halted=0.
- States:
  - IDLE: one cycle after reset release, memread=1; goes to FETCH.
  - FETCH: normal operation.
  - HALT: memread=1, halted=1.
  - ERR: memread=1, fetch_err=1; exited only by reset.
- FETCH, slot free: slot_free = !if_valid || id_ready.
  - memread=0 when !stall && slot_free; otherwise memread=1.
  - read_address = pc at all times; combinational, no glitching requirement beyond the register.
- Advance: advance = FETCH && memread==0 && !branch_taken && !flush.
  - On advance with instruction_re != HALT_WORD: if_instr<=instruction_re, if_pc<=pc, if_valid<=1, pc<=pc+4.
  - On advance with instruction_re == HALT_WORD: word not presented; if_valid<=0 if consumed, else held; pc held; go to HALT.
- Latency: one cycle from address presentation to if_valid.
- Consume without refill (stall, or memread=1): if if_valid && id_ready, then if_valid<=0.
- Backpressure (if_valid && !id_ready): if_instr, if_pc and if_valid held stable; pc held.
- pc arithmetic is modulo 2**ADDR_W: 60+4 wraps to 0, with no error.
- Redirect (branch_taken=1, any state except ERR): has priority over stall, flush and advance.
  - If branch_target[1:0]==0: pc<=branch_target, if_valid<=0, state<=FETCH (this exits HALT); the same-cycle memory word is discarded.
  - If branch_target[1:0]!=0: state<=ERR, if_valid<=0, pc unchanged.
- Flush without branch: if_valid<=0 and no capture this cycle; pc unchanged, so the same address is refetched next cycle.
- stall && flush: if_valid<=0, pc held.
- Reset mid-operation: all registers return to reset values immediately; in-flight word dropped.

Test Plan:
- Reset and sequential fetch. Hold reset_n=0 → memread=1, read_address=0, if_valid=0. Release reset with memory words 0x11111111, 0x22222222, 0x33333333 at bytes 0/4/8 and id_ready=1 → cycle 1 memread=1 (IDLE); cycles 2-4 present addresses 0/4/8; if_instr/if_pc appear one cycle later as (0x11111111,0), (0x22222222,4), (0x33333333,8).
- Backpressure. Drop id_ready=0 while if_pc=4 → memread=1, read_address=8, and if_instr=0x22222222 held for 3 cycles. Raise id_ready → next cycle if_pc=8.
- Branch priority. Assert branch_taken with target 0x20, together with stall=1, while if_valid=1 → next cycle if_valid=0 and read_address=0x20; the following capture gives if_pc=0x20.
- Misaligned target and wrap. Branch to 0x22 → fetch_err=1 and memread=1 permanently until reset_n pulse. Separately, branch to 60 (0x3C) → sequence of if_pc values is 60 then 0.
- Halt sentinel. Word at 12 = 0xFFFFFFFF → if_pc never equals 12, halted=1, memread=1. A branch to 0 clears halted and fetching resumes.
- Flush and reset mid-operation. Flush for one cycle → if_valid=0 and the same pc is refetched. Assert reset_n=0 mid-fetch → outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch sequencer feeding the instruction
// memory, with an IF/ID output register handshaking toward decode.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   stall                hold pc, issue no read
//   branch_taken/target  single-cycle redirect (highest priority)
//   flush                drop the IF/ID register contents
//   memread              memory read enable, active-low (combinational)
//   read_address         byte address to memory, always equal to pc
//   instruction_re       combinational big-endian word from memory
//   if_instr/if_pc       registered instruction and its address
//   if_valid, id_ready   valid/ready handshake toward decode
//   fetch_err            sticky misaligned-redirect error
//   halted               high while stopped on the halt sentinel
module fetch_unit #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = 6'd0,
  parameter logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               flush,
  output logic               memread,
  output logic [ADDR_W-1:0]  read_address,
  input  logic [INSTR_W-1:0] instruction_re,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_valid,
  input  logic               id_ready,
  output logic               fetch_err,
  output logic               halted
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_W / 8);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t               state, state_d;
  logic [ADDR_W-1:0]    pc, pc_d;
  logic [INSTR_W-1:0]   if_instr_d;
  logic [ADDR_W-1:0]    if_pc_d;
  logic                 if_valid_d;
  logic                 memread_c;
  logic                 slot_free;
  logic                 consumed;

  // State and IF/ID register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      if_instr <= '0;
      if_pc    <= '0;
      if_valid <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      if_instr <= if_instr_d;
      if_pc    <= if_pc_d;
      if_valid <= if_valid_d;
    end
  end

  // Next-state, read request and IF/ID update
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    if_instr_d = if_instr;
    if_pc_d    = if_pc;
    if_valid_d = if_valid;
    memread_c  = 1'b1;

    slot_free = !if_valid || id_ready;
    consumed  = if_valid && id_ready;

    if (state == S_FETCH && !stall && slot_free) begin
      memread_c = 1'b0;
    end

    if (state != S_ERR) begin
      if (state == S_IDLE) begin
        state_d = S_FETCH;
      end

      if (branch_taken) begin
        // Redirect wins over everything; the word read this cycle is dropped.
        if_valid_d = 1'b0;
        if (branch_target[1:0] == 2'b00) begin
          pc_d    = branch_target;
          state_d = S_FETCH;
        end else begin
          state_d = S_ERR;
        end
      end else if (flush) begin
        if_valid_d = 1'b0;
      end else if (state == S_FETCH && !memread_c) begin
        if (instruction_re != HALT_WORD) begin
          if_instr_d = instruction_re;
          if_pc_d    = pc;
          if_valid_d = 1'b1;
          pc_d       = pc + PC_STEP;
        end else begin
          // Sentinel is never presented; a still-pending word stays put.
          if (consumed) begin
            if_valid_d = 1'b0;
          end
          state_d = S_HALT;
        end
      end else if (consumed) begin
        if_valid_d = 1'b0;
      end
    end
  end

  assign memread      = memread_c;
  assign read_address = pc;
  assign fetch_err    = (state == S_ERR);
  assign halted       = (state == S_HALT);

endmodule
